video_timing: RTL and testbench



---
 rtl/video_timing_if.sv | 21 ++
 rtl/video_timing.sv | 115 +++++++++++
 tb/tb_video_timing.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel position plus the sync, enable, blanking and
// line/frame markers that the video fetch and pixel output stages consume.
interface video_timing_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        vblank;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output x, y, de, hsync, vsync, vblank, line_start, frame_start, frame_count
  );

  modport slave (
    input  x, y, de, hsync, vsync, vblank, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical pixel counters with registered
// sync, data-enable, blanking and line/frame markers aligned to the counters.
module video_timing #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic           clock,
  input  logic           reset_n,
  video_timing_if.master video_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_zero
      $error("video_timing: every timing parameter must be non-zero");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
      $error("video_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_POL   = 1'(HSYNC_POL);
  localparam logic        VS_POL   = 1'(VSYNC_POL);

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic vblank;
    logic line_start;
    logic frame_start;
  } marks_t;

  // Markers for a given position; pulses=0 suppresses line/frame start so the
  // same decode also yields the reset image of the last pixel of a frame.
  function automatic marks_t marks_at(input logic [10:0] px,
                                      input logic [10:0] py,
                                      input logic        pulses);
    marks_t m;
    m.de          = (px < H_ACT) && (py < V_ACT);
    m.hsync       = ~(((px >= HS_START) && (px < HS_END)) ^ HS_POL);
    m.vsync       = ~(((py >= VS_START) && (py < VS_END)) ^ VS_POL);
    m.vblank      = (py >= V_ACT);
    m.line_start  = pulses && (px == '0);
    m.frame_start = pulses && (px == '0) && (py == '0);
    return m;
  endfunction

  localparam marks_t RST_MARKS = marks_at(H_LAST, V_LAST, 1'b0);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  marks_t      marks_q, marks_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        x_wrap;

  // Markers decode the next position so they register alongside the counters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    x_wrap = (x_q == H_LAST);
    x_d    = x_wrap ? '0 : x_q + 11'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
    end
    marks_d       = marks_at(x_d, y_d, 1'b1);
    frame_count_d = frame_count_q + {7'd0, marks_d.frame_start};
  end

  // NOTE: reset is synchronous here, so it is tested inside the clocked block with no reset in the sensitivity list.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      marks_q       <= RST_MARKS;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      marks_q       <= marks_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign video_o.x           = x_q;
  assign video_o.y           = y_q;
  assign video_o.de          = marks_q.de;
  assign video_o.hsync       = marks_q.hsync;
  assign video_o.vsync       = marks_q.vsync;
  assign video_o.vblank      = marks_q.vblank;
  assign video_o.line_start  = marks_q.line_start;
  assign video_o.frame_start = marks_q.frame_start;
  assign video_o.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: full-size timing for reset and line checks,
// a scaled-down raster (16x10) for frame, wrap, mid-frame reset and polarity.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst_def_n;
  logic rst_sm_n;

  always #5 clk = ~clk;

  video_timing_if vid_def ();
  video_timing_if vid_sm ();
  video_timing_if vid_pol ();

  video_timing u_def (
    .clock   (clk),
    .reset_n (rst_def_n),
    .video_o (vid_def)
  );

  // Small raster: H 8+2+3+3 = 16 (hsync x 10..12), V 6+1+2+1 = 10 (vsync y 7..8).
  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) u_sm (
    .clock   (clk),
    .reset_n (rst_sm_n),
    .video_o (vid_sm)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1)
  ) u_pol (
    .clock   (clk),
    .reset_n (rst_sm_n),
    .video_o (vid_pol)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_def_reset(input string p);
    check({p, ".x"},   32'(vid_def.x), 1343);
    check({p, ".y"},   32'(vid_def.y), 805);
    check({p, ".de"},  32'(vid_def.de), 0);
    check({p, ".hs"},  32'(vid_def.hsync), 1);
    check({p, ".vs"},  32'(vid_def.vsync), 1);
    check({p, ".vb"},  32'(vid_def.vblank), 1);
    check({p, ".ls"},  32'(vid_def.line_start), 0);
    check({p, ".fs"},  32'(vid_def.frame_start), 0);
    check({p, ".fc"},  32'(vid_def.frame_count), 0);
  endtask

  task automatic chk_def_origin(input string p);
    check({p, ".x"},   32'(vid_def.x), 0);
    check({p, ".y"},   32'(vid_def.y), 0);
    check({p, ".de"},  32'(vid_def.de), 1);
    check({p, ".hs"},  32'(vid_def.hsync), 1);
    check({p, ".vb"},  32'(vid_def.vblank), 0);
    check({p, ".ls"},  32'(vid_def.line_start), 1);
    check({p, ".fs"},  32'(vid_def.frame_start), 1);
    check({p, ".fc"},  32'(vid_def.frame_count), 1);
  endtask

  task automatic chk_sm_reset(input string p);
    check({p, ".x"},     32'(vid_sm.x), 15);
    check({p, ".y"},     32'(vid_sm.y), 9);
    check({p, ".de"},    32'(vid_sm.de), 0);
    check({p, ".hs"},    32'(vid_sm.hsync), 1);
    check({p, ".vs"},    32'(vid_sm.vsync), 1);
    check({p, ".vb"},    32'(vid_sm.vblank), 1);
    check({p, ".ls"},    32'(vid_sm.line_start), 0);
    check({p, ".fs"},    32'(vid_sm.frame_start), 0);
    check({p, ".fc"},    32'(vid_sm.frame_count), 0);
    check({p, ".pol_hs"}, 32'(vid_pol.hsync), 0);
    check({p, ".pol_vs"}, 32'(vid_pol.vsync), 0);
  endtask

  task automatic chk_sm_origin(input string p);
    check({p, ".x"},     32'(vid_sm.x), 0);
    check({p, ".y"},     32'(vid_sm.y), 0);
    check({p, ".de"},    32'(vid_sm.de), 1);
    check({p, ".vs"},    32'(vid_sm.vsync), 1);
    check({p, ".ls"},    32'(vid_sm.line_start), 1);
    check({p, ".fs"},    32'(vid_sm.frame_start), 1);
    check({p, ".fc"},    32'(vid_sm.frame_count), 1);
    check({p, ".pol_hs"}, 32'(vid_pol.hsync), 0);
    check({p, ".pol_fs"}, 32'(vid_pol.frame_start), 1);
  endtask

  initial begin
    int de_cnt, de_first, de_last, hs_cnt, hs_first, hs_last, ls_cnt, ls_bad, x_bad;
    int fde_cnt[2];
    int vs_cnt, vs_min_y, vs_max_y, vs_edge_bad, vb_cnt, vb_bad;
    int ph_cnt, ph_min_x, ph_max_x, pv_cnt, fs_cnt, fs_prev_t, fs_gap, sls_cnt, sls_bad;
    logic prev_vs;

    rst_def_n = 1'b0;
    rst_sm_n  = 1'b0;
    step(5);
    chk_def_reset("def_rst");
    chk_sm_reset("sm_rst");

    rst_def_n = 1'b1;
    step(1);
    chk_def_origin("def_rel");

    // One full line at default timing, starting from the x=0 sample.
    de_cnt = 0; de_first = -1; de_last = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; ls_bad = 0; x_bad = 0;
    for (int i = 0; i < 1344; i++) begin
      if (int'(vid_def.x) != i) x_bad++;
      if (vid_def.de) begin
        de_cnt++;
        if (de_first < 0) de_first = i;
        de_last = i;
      end
      if (!vid_def.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (vid_def.line_start) begin
        ls_cnt++;
        if (i != 0) ls_bad++;
      end
      step(1);
    end
    check("line.x_seq_err",  x_bad, 0);
    check("line.de_cnt",     de_cnt, 1024);
    check("line.de_first",   de_first, 0);
    check("line.de_last",    de_last, 1023);
    check("line.hs_cnt",     hs_cnt, 136);
    check("line.hs_first",   hs_first, 1048);
    check("line.hs_last",    hs_last, 1183);
    check("line.ls_cnt",     ls_cnt, 1);
    check("line.ls_off0",    ls_bad, 0);
    check("line2.x",  32'(vid_def.x), 0);
    check("line2.y",  32'(vid_def.y), 1);
    check("line2.ls", 32'(vid_def.line_start), 1);
    check("line2.fs", 32'(vid_def.frame_start), 0);
    check("line2.fc", 32'(vid_def.frame_count), 1);

    // Mid-line reset on the default raster while hsync is active.
    step(1100);
    check("defmid.x",  32'(vid_def.x), 1100);
    check("defmid.y",  32'(vid_def.y), 1);
    check("defmid.hs", 32'(vid_def.hsync), 0);
    rst_def_n = 1'b0;
    step(1);
    chk_def_reset("defmid_rst");
    rst_def_n = 1'b1;
    step(1);
    chk_def_origin("defmid_rel");

    // Small raster: two full frames tallied cycle by cycle.
    rst_sm_n = 1'b1;
    step(1);
    chk_sm_origin("sm_rel");

    fde_cnt[0] = 0; fde_cnt[1] = 0;
    vs_cnt = 0; vs_min_y = 99; vs_max_y = -1; vs_edge_bad = 0;
    vb_cnt = 0; vb_bad = 0;
    ph_cnt = 0; ph_min_x = 99; ph_max_x = -1; pv_cnt = 0;
    fs_cnt = 0; fs_prev_t = -1; fs_gap = 0; sls_cnt = 0; sls_bad = 0;
    prev_vs = vid_sm.vsync;
    for (int t = 0; t < 320; t++) begin
      if (vid_sm.de) fde_cnt[t / 160]++;
      if (!vid_sm.vsync) begin
        vs_cnt++;
        if (int'(vid_sm.y) < vs_min_y) vs_min_y = int'(vid_sm.y);
        if (int'(vid_sm.y) > vs_max_y) vs_max_y = int'(vid_sm.y);
      end
      if (vid_sm.vsync != prev_vs && vid_sm.x != 11'd0) vs_edge_bad++;
      prev_vs = vid_sm.vsync;
      if (vid_sm.vblank) vb_cnt++;
      if (vid_sm.vblank != (vid_sm.y >= 11'd6)) vb_bad++;
      if (vid_pol.hsync) begin
        ph_cnt++;
        if (int'(vid_pol.x) < ph_min_x) ph_min_x = int'(vid_pol.x);
        if (int'(vid_pol.x) > ph_max_x) ph_max_x = int'(vid_pol.x);
      end
      if (vid_pol.vsync) pv_cnt++;
      if (vid_sm.frame_start) begin
        fs_cnt++;
        if (fs_prev_t >= 0) fs_gap = t - fs_prev_t;
        fs_prev_t = t;
      end
      if (vid_sm.line_start) begin
        sls_cnt++;
        if (vid_sm.x != 11'd0) sls_bad++;
      end
      if (t == 159) begin
        check("wrap.pre_x", 32'(vid_sm.x), 15);
        check("wrap.pre_y", 32'(vid_sm.y), 9);
      end
      step(1);
    end
    check("frm.de0",      fde_cnt[0], 48);
    check("frm.de1",      fde_cnt[1], 48);
    check("frm.vs_cnt",   vs_cnt, 64);
    check("frm.vs_min_y", vs_min_y, 7);
    check("frm.vs_max_y", vs_max_y, 8);
    check("frm.vs_edge",  vs_edge_bad, 0);
    check("frm.vb_cnt",   vb_cnt, 128);
    check("frm.vb_err",   vb_bad, 0);
    check("pol.hs_cnt",   ph_cnt, 60);
    check("pol.hs_min_x", ph_min_x, 10);
    check("pol.hs_max_x", ph_max_x, 12);
    check("pol.vs_cnt",   pv_cnt, 64);
    check("frm.fs_cnt",   fs_cnt, 2);
    check("frm.fs_gap",   fs_gap, 160);
    check("frm.ls_cnt",   sls_cnt, 20);
    check("frm.ls_off0",  sls_bad, 0);
    check("frm3.x",  32'(vid_sm.x), 0);
    check("frm3.y",  32'(vid_sm.y), 0);
    check("frm3.fs", 32'(vid_sm.frame_start), 1);
    check("frm3.fc", 32'(vid_sm.frame_count), 3);

    // frame_count roll-over 255 -> 0.
    step(252 * 160);
    check("fc255.x",  32'(vid_sm.x), 0);
    check("fc255.fc", 32'(vid_sm.frame_count), 255);
    step(159);
    check("fcpre.x",  32'(vid_sm.x), 15);
    check("fcpre.y",  32'(vid_sm.y), 9);
    check("fcpre.fc", 32'(vid_sm.frame_count), 255);
    step(1);
    check("fc0.x",  32'(vid_sm.x), 0);
    check("fc0.y",  32'(vid_sm.y), 0);
    check("fc0.fs", 32'(vid_sm.frame_start), 1);
    check("fc0.fc", 32'(vid_sm.frame_count), 0);

    // Mid-frame reset with both syncs active (x=11, y=7).
    step(7 * 16 + 11);
    check("smmid.x",      32'(vid_sm.x), 11);
    check("smmid.y",      32'(vid_sm.y), 7);
    check("smmid.hs",     32'(vid_sm.hsync), 0);
    check("smmid.vs",     32'(vid_sm.vsync), 0);
    check("smmid.pol_hs", 32'(vid_pol.hsync), 1);
    check("smmid.pol_vs", 32'(vid_pol.vsync), 1);
    rst_sm_n = 1'b0;
    step(1);
    chk_sm_reset("smmid_rst");
    rst_sm_n = 1'b1;
    step(1);
    chk_sm_origin("smmid_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
